l4_feature_reader: RTL and testbench
====================================

Name: l4_feature_reader

Overview:
- Reads the pooled L4 feature map out of the L4 output BRAM after pooling completes and streams it to the fully-connected stage.
- Issues BRAM read addresses, absorbs the fixed BRAM read latency and drives a valid/ready output stream.
- Output order is flattened channel-major: channel 0 positions 0..24, then channel 1, and so on.
- Sits on the BRAM read port opposite the pooling write side. Its start input is driven from the pooling block's pool_done pulse.

Parameters:
- DATA_WIDTH, 16, width of one feature word.
- ADDR_WIDTH, 9, L4 BRAM address width.
- NUM_CH, 16, number of pooled channels.
- CH_WORDS, 25, words per channel (5x5).
- RD_LAT, 1, BRAM read latency in cycles (supported values 1..2).
- FIFO_DEPTH, 4, output buffer depth; must be at least RD_LAT+2.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a full read of NUM_CH*CH_WORDS words; ignored while busy.
- base_position, in, 12, BRAM start address; sampled on an accepted start.
- L4_output_read_addr, out, ADDR_WIDTH, BRAM read address.
- L4_output_rd_en, out, 1, BRAM read enable.
- L4_output_dout, in, DATA_WIDTH, BRAM read data; valid RD_LAT cycles after rd_en.
- feat_data, out, DATA_WIDTH, stream data.
- feat_valid, out, 1, stream valid.
- feat_ready, in, 1, stream ready from the consumer.
- feat_last, out, 1, high with the final word (index NUM_CH*CH_WORDS-1).
- feat_ch, out, 4, channel index of feat_data.
- busy, out, 1, high from accepted start until done.
- read_done, out, 1, one-cycle pulse after the last handshake.

Behaviour:
- Reset values: every output is 0; FSM goes to IDLE; counters, FIFO pointers and the outstanding count are cleared.
- Handshake rules:
  - A transfer occurs on a cycle where feat_valid and feat_ready are both high.
  - Once valid is asserted, feat_data, feat_valid, feat_last and feat_ch hold stable until the transfer.
  - feat_valid never depends combinationally on feat_ready.
- FSM:
  - IDLE: on start go to READ, latch base_position, clear rd_cnt and ch/pos counters, set busy.
  - READ: issue one read per cycle while (fifo_count + outstanding) < FIFO_DEPTH.
    - Address is base + rd_cnt, truncated to ADDR_WIDTH.
    - Position counter wraps 24 -> 0 and increments the channel.
    - After issuing rd_cnt = NUM_CH*CH_WORDS-1, go to DRAIN.
  - DRAIN: issue no reads. When the last word transfers, go to DONE.
  - DONE: read_done high for one cycle, busy low, then IDLE.
- Latency: without backpressure, first feat_valid appears RD_LAT+1 cycles after start; throughput is then one word per cycle.
- Pipeline:
  - A valid bit plus channel/last tag pipeline of depth RD_LAT, aligned to rd_en, captures L4_output_dout into the FIFO.
  - The credit check guarantees the FIFO never overflows, even when feat_ready is held low indefinitely.
- Boundaries:
  - start asserted while busy: ignored.
  - start on the same cycle as read_done: ignored, because the FSM is not yet in IDLE.
  - Push and pop on the same cycle: count unchanged.
  - FIFO empty: feat_valid low.
  - rst mid-operation: abort immediately, flush the FIFO and drop in-flight reads. Stale BRAM data returning after reset is discarded because the tag pipeline is cleared.
  - feat_ready held low at the last word: stay in DRAIN; read_done is delayed until the transfer.

Decomposition:
- Shared package l4_pkg:
  - constants: L4_NUM_CH=16, L4_CH_WORDS=25, L4_TOTAL_WORDS=400, L4_ADDR_WIDTH=9.
  - FSM state enum: IDLE, READ, DRAIN, DONE.
- One sub-module: l4_rd_fifo.
  - Synchronous FIFO, parameterised width and depth.
  - Registered output with first-word fall-through.
  - Provides count, push, pop, empty and full.

Test Plan:
- Reset, start with base_position=0 and feat_ready=1:
  - addresses 0..399 on consecutive cycles;
  - first feat_valid at cycle RD_LAT+1;
  - 400 words equal to BRAM contents (mem[i]=i);
  - feat_ch=0 for indices 0..24 and 15 for indices 375..399;
  - feat_last only on index 399;
  - read_done one cycle after.
- base_position=100, feat_ready toggling 1,0,0,1 pattern:
  - data sequence mem[100..499] with no loss or duplication;
  - outputs hold stable while stalled;
  - FIFO count never exceeds 4.
- feat_ready=0 for 50 cycles after start:
  - exactly FIFO_DEPTH reads issued, then rd_en stays low;
  - on release the stream resumes in order.
- Second start pulse at word 37:
  - ignored; the stream completes 400 words and read_done fires once.
- rst asserted at word 200 with a read in flight:
  - all outputs 0 next cycle;
  - no feat_valid from stale data;
  - a new start then streams from index 0 correctly.
- RD_LAT=2 build: same as the first scenario with first valid at cycle 3.

Source files
------------

// File: rtl/l4_pkg.sv
// Shared constants and FSM state encodings for the L4 feature-map reader.
package l4_pkg;

    localparam int unsigned L4_NUM_CH      = 16;
    localparam int unsigned L4_CH_WORDS    = 25;
    localparam int unsigned L4_TOTAL_WORDS = L4_NUM_CH * L4_CH_WORDS;
    localparam int unsigned L4_ADDR_WIDTH  = 9;
    localparam int unsigned L4_DATA_WIDTH  = 16;
    localparam int unsigned L4_CH_WIDTH    = 4;
    localparam int unsigned L4_BASE_WIDTH  = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/l4_rd_fifo.sv
// Small synchronous FIFO with a registered first-word-fall-through output stage.
module l4_rd_fifo #(
    parameter  int unsigned WIDTH = 21,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    // One entry lives in the output register, the rest in the backing buffer.
    localparam int unsigned BUF_DEPTH = DEPTH - 1;
    localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_buf_cnt;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_out_vld;
    logic             r_empty;
    logic             r_full;

    logic             w_pop;
    logic             w_load;
    logic             w_buf_empty;
    logic             w_bypass;
    logic             w_buf_wr;
    logic             w_buf_rd;
    logic [CNT_W-1:0] w_count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop       = i_pop & r_out_vld;
    assign w_load      = ~r_out_vld | w_pop;
    assign w_buf_empty = (r_buf_cnt == '0);
    assign w_bypass    = i_push & w_load & w_buf_empty;
    assign w_buf_wr    = i_push & ~w_bypass;
    assign w_buf_rd    = w_load & ~w_buf_empty;
    assign w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_buf_cnt <= '0;
            r_count   <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
        end else begin
            if (w_buf_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_buf_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_buf_cnt <= r_buf_cnt + CNT_W'(w_buf_wr) - CNT_W'(w_buf_rd);
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == CNT_W'(DEPTH));
            // Output stage refills from the buffer head first, else straight from the push.
            if (w_load) begin
                if (!w_buf_empty) begin
                    r_out     <= r_buf[r_rd_ptr];
                    r_out_vld <= 1'b1;
                end else if (i_push) begin
                    r_out     <= i_data;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
        end
    end

    assign o_data  = r_out;
    assign o_valid = r_out_vld;
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/l4_feature_reader.sv
// Streams the pooled L4 feature map out of BRAM in channel-major order,
// throttling reads with a credit check so the output FIFO can never overflow.
module l4_feature_reader
    import l4_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = L4_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = L4_ADDR_WIDTH,
    parameter int unsigned NUM_CH     = L4_NUM_CH,
    parameter int unsigned CH_WORDS   = L4_CH_WORDS,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [L4_BASE_WIDTH-1:0] base_position,
    output logic [ADDR_WIDTH-1:0]    L4_output_read_addr,
    output logic                     L4_output_rd_en,
    input  logic [DATA_WIDTH-1:0]    L4_output_dout,
    output logic [DATA_WIDTH-1:0]    feat_data,
    output logic                     feat_valid,
    input  logic                     feat_ready,
    output logic                     feat_last,
    output logic [L4_CH_WIDTH-1:0]   feat_ch,
    output logic                     busy,
    output logic                     read_done
);

    localparam int unsigned TOTAL  = NUM_CH * CH_WORDS;
    localparam int unsigned RCNT_W = $clog2(TOTAL + 1);
    localparam int unsigned POS_W  = $clog2(CH_WORDS);
    localparam int unsigned CH_W   = L4_CH_WIDTH;
    localparam int unsigned BASE_W = L4_BASE_WIDTH;
    localparam int unsigned FIFO_W = DATA_WIDTH + CH_W + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [1:0]            r_state;
    logic [BASE_W-1:0]     r_base;
    logic [RCNT_W-1:0]     r_rd_cnt;
    logic [POS_W-1:0]      r_pos;
    logic [CH_W-1:0]       r_ch;
    logic [CNT_W-1:0]      r_outst;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CH_W-1:0]       r_iss_ch;
    logic                  r_iss_last;
    logic [RD_LAT-1:0]     r_pv;
    logic [CH_W-1:0]       r_pch [RD_LAT];
    logic [RD_LAT-1:0]     r_plast;
    logic                  r_busy;
    logic                  r_read_done;

    logic [1:0]            w_state_nxt;
    logic                  w_issue;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [RCNT_W-1:0]     w_idx;
    logic [POS_W-1:0]      w_idx_pos;
    logic [CH_W-1:0]       w_idx_ch;
    logic [BASE_W-1:0]     w_addr_base;
    logic                  w_iss_last;
    logic                  w_pos_wrap;

    logic                  w_push;
    logic [FIFO_W-1:0]     w_fifo_din;
    logic [FIFO_W-1:0]     w_fifo_dout;
    logic                  w_fifo_valid;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_xfer_last;

    // A word popped this cycle frees its slot before any newly issued read can land.
    assign w_pop       = feat_ready & ~w_fifo_empty;
    assign w_credit_ok = ((CNT_W+1)'(w_fifo_cnt) + (CNT_W+1)'(r_outst)
                          < (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(w_pop)) & ~w_fifo_full;
    assign w_xfer_last = w_fifo_valid & feat_ready & w_fifo_dout[FIFO_W-1];
    assign w_push      = r_pv[RD_LAT-1];
    assign w_fifo_din  = {r_plast[RD_LAT-1], r_pch[RD_LAT-1], L4_output_dout};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the read-issue decision; the accepted start issues word 0 itself.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_idx       = r_rd_cnt;
        w_idx_pos   = r_pos;
        w_idx_ch    = r_ch;
        w_addr_base = r_base;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_issue     = 1'b1;
                    w_idx       = '0;
                    w_idx_pos   = '0;
                    w_idx_ch    = '0;
                    w_addr_base = base_position;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_rd_cnt == RCNT_W'(TOTAL - 1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_xfer_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_iss_last = (w_idx == RCNT_W'(TOTAL - 1));
        w_pos_wrap = (w_idx_pos == POS_W'(CH_WORDS - 1));
    end

    // Read issue, position/channel counters and the credit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_rd_cnt    <= '0;
            r_pos       <= '0;
            r_ch        <= '0;
            r_outst     <= '0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_iss_ch    <= '0;
            r_iss_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_read_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_base <= base_position;
            end
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_addr     <= ADDR_WIDTH'(w_addr_base + BASE_W'(w_idx));
                r_iss_ch   <= w_idx_ch;
                r_iss_last <= w_iss_last;
                r_rd_cnt   <= w_idx + RCNT_W'(1);
                r_pos      <= w_pos_wrap ? '0 : w_idx_pos + POS_W'(1);
                r_ch       <= w_pos_wrap ? w_idx_ch + CH_W'(1) : w_idx_ch;
            end
            r_outst     <= r_outst + CNT_W'(w_issue) - CNT_W'(w_push);
            r_busy      <= w_busy_nxt;
            r_read_done <= w_done_nxt;
        end
    end

    // Tag pipeline tracks each read until its BRAM data is valid; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv    <= '0;
            r_plast <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                r_pch[k] <= '0;
            end
        end else begin
            r_pv[0]    <= r_rd_en;
            r_pch[0]   <= r_iss_ch;
            r_plast[0] <= r_iss_last;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_pch[k]   <= r_pch[k-1];
                r_plast[k] <= r_plast[k-1];
            end
        end
    end

    l4_rd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (feat_ready),
        .o_data  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign L4_output_read_addr = r_addr;
    assign L4_output_rd_en     = r_rd_en;
    assign feat_data           = w_fifo_dout[DATA_WIDTH-1:0];
    assign feat_ch             = w_fifo_dout[DATA_WIDTH +: CH_W];
    assign feat_last           = w_fifo_dout[FIFO_W-1];
    assign feat_valid          = w_fifo_valid;
    assign busy                = r_busy;
    assign read_done           = r_read_done;

endmodule

// File: tb/tb_l4_feature_reader.sv
// Directed bench for l4_feature_reader: BRAM models hold mem[i]=i, one DUT per read latency.
module tb_l4_feature_reader;
    import l4_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start2;
    logic [11:0] base;
    logic        ready;

    logic [8:0]  addr1,  addr2;
    logic        rden1,  rden2;
    logic [15:0] dout1,  dout2, d2a;
    logic [15:0] data1,  data2;
    logic        valid1, valid2;
    logic        last1,  last2;
    logic [3:0]  ch1,    ch2;
    logic        busy1,  busy2;
    logic        done1,  done2;

    int total = 0;
    int bad   = 0;
    int n_iss, n_xfer, n_done, exp_base;
    int first_iss_t, last_iss_t, t_last, t_done, cyc;
    int n2_xfer, n2_done;
    bit mon2;
    bit sent2;
    bit prev_hold;
    logic [15:0] prev_data;
    logic [3:0]  prev_ch;
    logic        prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    l4_feature_reader #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_position(base),
        .L4_output_read_addr(addr1), .L4_output_rd_en(rden1), .L4_output_dout(dout1),
        .feat_data(data1), .feat_valid(valid1), .feat_ready(ready), .feat_last(last1),
        .feat_ch(ch1), .busy(busy1), .read_done(done1)
    );

    l4_feature_reader #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_position(base),
        .L4_output_read_addr(addr2), .L4_output_rd_en(rden2), .L4_output_dout(dout2),
        .feat_data(data2), .feat_valid(valid2), .feat_ready(ready), .feat_last(last2),
        .feat_ch(ch2), .busy(busy2), .read_done(done2)
    );

    // BRAM contents mem[i] = i; latency 1 and 2 respectively.
    always @(posedge clk) begin
        if (rden1) dout1 <= 16'(addr1);
        if (rden2) d2a <= 16'(addr2);
        dout2 <= d2a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input int b);
        n_iss = 0; n_xfer = 0; n_done = 0; exp_base = b;
        first_iss_t = -1; last_iss_t = -1; t_last = -100; t_done = -1;
        n2_xfer = 0; n2_done = 0; prev_hold = 0;
    endtask

    // Mid-cycle monitor: address order, credit bound, stall stability and stream contents.
    task automatic sample();
        logic [8:0] a;
        if (rden1) begin
            a = 9'(exp_base + n_iss);
            chk("rd_addr", 32'(addr1), 32'(a));
            if (n_iss == 0) first_iss_t = cyc;
            last_iss_t = cyc;
            n_iss++;
        end
        if (n_iss > 0) chk("credit", 32'((n_iss - n_xfer) <= 4), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(valid1), 32'd1);
            chk("hold_data",  32'(data1),  32'(prev_data));
            chk("hold_ch",    32'(ch1),    32'(prev_ch));
            chk("hold_last",  32'(last1),  32'(prev_last));
        end
        if (valid1 && ready) begin
            a = 9'(exp_base + n_xfer);
            chk("data", 32'(data1), 32'(a));
            chk("ch",   32'(ch1),   32'(n_xfer / 25));
            chk("last", 32'(last1), 32'(n_xfer == L4_TOTAL_WORDS - 1));
            if (last1) t_last = cyc;
            n_xfer++;
        end
        if (done1) begin
            n_done++;
            t_done = cyc;
        end
        prev_hold = valid1 && !ready;
        prev_data = data1;
        prev_ch   = ch1;
        prev_last = last1;
        if (mon2 && valid2 && ready) begin
            chk("lat2_data", 32'(data2), 32'(n2_xfer));
            chk("lat2_last", 32'(last2), 32'(n2_xfer == L4_TOTAL_WORDS - 1));
            n2_xfer++;
        end
        if (mon2 && done2) n2_done++;
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  32'(rden1),  32'd0);
        chk({tag, "_addr"},  32'(addr1),  32'd0);
        chk({tag, "_valid"}, 32'(valid1), 32'd0);
        chk({tag, "_data"},  32'(data1),  32'd0);
        chk({tag, "_last"},  32'(last1),  32'd0);
        chk({tag, "_ch"},    32'(ch1),    32'd0);
        chk({tag, "_busy"},  32'(busy1),  32'd0);
        chk({tag, "_done"},  32'(done1),  32'd0);
    endtask

    task automatic start_run(input logic [11:0] b, input bit both);
        clear_mon(int'(b));
        base   = b;
        start  = 1'b1;
        start2 = both;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
        cyc    = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; base = '0; ready = 1'b1;
        mon2 = 0; sent2 = 0; cyc = 0;
        clear_mon(0);
        repeat (3) begin @(posedge clk); #1; end
        chk_all_zero("reset");
        chk("reset_valid2", 32'(valid2), 32'd0);
        rst = 1'b0;
        tick();

        // Full stream, no backpressure, both latencies.
        mon2 = 1;
        start_run(12'd0, 1'b1);
        chk("s1_busy", 32'(busy1), 32'd1);
        for (int k = 0; k < 1000 && !(n_done > 0 && n2_done > 0); k++) begin
            if (cyc == 1) chk("lat1_pre", 32'(valid1), 32'd0);
            if (cyc == 2) begin
                chk("lat1_first", 32'(valid1), 32'd1);
                chk("lat2_pre",   32'(valid2), 32'd0);
            end
            if (cyc == 3) chk("lat2_first", 32'(valid2), 32'd1);
            tick();
        end
        chk("s1_timeout", 32'(n_done > 0 && n2_done > 0), 32'd1);
        chk("s1_words", 32'(n_xfer), 32'd400);
        chk("s1_reads", 32'(n_iss), 32'd400);
        chk("s1_consecutive", 32'(last_iss_t - first_iss_t), 32'd399);
        chk("s1_done_lag", 32'(t_done - t_last), 32'd1);
        chk("s1_done_once", 32'(n_done), 32'd1);
        chk("s2lat_words", 32'(n2_xfer), 32'd400);
        chk("s2lat_done", 32'(n2_done), 32'd1);
        chk("s1_idle_busy", 32'(busy1), 32'd0);
        mon2 = 0;
        tick();

        // Base 100 with ready pattern 1,0,0,1.
        start_run(12'd100, 1'b0);
        for (int k = 0; k < 3000 && n_done == 0; k++) begin
            ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
        end
        ready = 1'b1;
        chk("s2_timeout", 32'(n_done > 0), 32'd1);
        chk("s2_words", 32'(n_xfer), 32'd400);
        chk("s2_reads", 32'(n_iss), 32'd400);
        chk("s2_done_once", 32'(n_done), 32'd1);
        tick();

        // Consumer stalled for 50 cycles right after start.
        ready = 1'b0;
        start_run(12'd7, 1'b0);
        repeat (49) tick();
        chk("s3_reads_stalled", 32'(n_iss), 32'd4);
        chk("s3_rden_low", 32'(rden1), 32'd0);
        chk("s3_valid_held", 32'(valid1), 32'd1);
        ready = 1'b1;
        for (int k = 0; k < 1000 && n_done == 0; k++) tick();
        chk("s3_timeout", 32'(n_done > 0), 32'd1);
        chk("s3_words", 32'(n_xfer), 32'd400);
        chk("s3_done_once", 32'(n_done), 32'd1);
        tick();

        // Start while busy at word 37, and start coinciding with read_done.
        start_run(12'd3, 1'b0);
        sent2 = 0;
        for (int k = 0; k < 1000 && n_done == 0; k++) begin
            start = 1'b0;
            if (n_xfer == 37 && !sent2) begin
                start = 1'b1;
                base  = 12'd250;
                sent2 = 1;
            end else if (done1) begin
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        chk("s4_timeout", 32'(n_done > 0), 32'd1);
        chk("s4_words", 32'(n_xfer), 32'd400);
        chk("s4_reads", 32'(n_iss), 32'd400);
        chk("s4_done_once", 32'(n_done), 32'd1);
        chk("s4_busy_after", 32'(busy1), 32'd0);
        chk("s4_rden_after", 32'(rden1), 32'd0);

        // Reset at word 200 with reads in flight, then a clean restart.
        start_run(12'd0, 1'b0);
        for (int k = 0; k < 1000 && n_xfer < 200; k++) tick();
        chk("s5_reach200", 32'(n_xfer >= 200), 32'd1);
        chk("s5_inflight", 32'(rden1), 32'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        clear_mon(0);
        for (int k = 0; k < 4; k++) begin
            chk("s5_stale_valid", 32'(valid1), 32'd0);
            tick();
        end
        start_run(12'd0, 1'b0);
        for (int k = 0; k < 1000 && n_done == 0; k++) tick();
        chk("s5_timeout", 32'(n_done > 0), 32'd1);
        chk("s5_words", 32'(n_xfer), 32'd400);
        chk("s5_reads", 32'(n_iss), 32'd400);
        chk("s5_done_once", 32'(n_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
